// File: rtl/instruction_fetch_register.sv
// Instruction register with immediate-format pre-decode.
// Requests a word over the MOV/MFC handshake, latches it into IR and, on the
// same edge, registers the extender controls (SISE, EN) and ImmValid so that
// the extender and operand-B mux always see IR together with its format.
//
// Ports:
//   Clk       rising-edge clock
//   Clr       asynchronous active-low reset
//   IR_LD     fetch request from the control unit
//   Flush     abort any fetch and load NOP_WORD
//   MFC       memory function complete (MemData valid while high)
//   MemData   instruction word from memory
//   MOV       memory read request
//   IR        latched instruction (extender input)
//   SISE      immediate format select to the extender
//   EN        sign-extension enable to the extender
//   ImmValid  IR carries an immediate operand
//   IRV       IR holds a freshly fetched instruction
//   FetchErr  last fetch timed out (sticky until the next request)
module instruction_fetch_register #(
  parameter int unsigned TIMEOUT      = 15,
  parameter logic        SEXT_DEFAULT = 1'b0,
  parameter logic [31:0] NOP_WORD     = 32'hE1A00000
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        IR_LD,
  input  logic        Flush,
  input  logic        MFC,
  input  logic [31:0] MemData,
  output logic        MOV,
  output logic [31:0] IR,
  output logic [1:0]  SISE,
  output logic        EN,
  output logic        ImmValid,
  output logic        IRV,
  output logic        FetchErr
);

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned DEC_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              mov_nxt;
  logic [31:0]       ir_nxt;
  logic [DEC_W-1:0]  dec_nxt;
  logic              irv_nxt;
  logic              err_nxt;

  // Immediate-format decode; returns {SISE, ImmValid, EN}.
  // Takes only the opcode fields it inspects: op = [27:25], b22 = [22], lo = [7:4].
  function automatic logic [DEC_W-1:0] decode(input logic [2:0] op,
                                              input logic       b22,
                                              input logic [3:0] lo);
    logic [1:0] s;
    logic       v;
    s = 2'b11;
    v = 1'b0;
    case (op)
      3'b001: begin s = 2'b00; v = 1'b1; end
      3'b010: begin s = 2'b01; v = 1'b1; end
      3'b000: begin
        // Halfword transfer with split immediate offset {[11:8],[3:0]}.
        if (b22 && lo[3] && lo[0] && (lo[2:1] != 2'b00)) begin
          s = 2'b10;
          v = 1'b1;
        end
      end
      default: ;
    endcase
    return {s, v, v & SEXT_DEFAULT};
  endfunction

  // State and output registers.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state    <= IDLE;
      cnt      <= '0;
      MOV      <= 1'b0;
      IR       <= '0;
      SISE     <= 2'b00;
      ImmValid <= 1'b0;
      EN       <= 1'b0;
      IRV      <= 1'b0;
      FetchErr <= 1'b0;
    end else begin
      state                  <= state_nxt;
      cnt                    <= cnt_nxt;
      MOV                    <= mov_nxt;
      IR                     <= ir_nxt;
      {SISE, ImmValid, EN}   <= dec_nxt;
      IRV                    <= irv_nxt;
      FetchErr               <= err_nxt;
    end
  end

  // Next-state and next-output logic; priority Flush > MFC > timeout > IR_LD.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mov_nxt   = MOV;
    ir_nxt    = IR;
    dec_nxt   = {SISE, ImmValid, EN};
    irv_nxt   = IRV;
    err_nxt   = FetchErr;

    if (Flush) begin
      state_nxt = IDLE;
      ir_nxt    = NOP_WORD;
      dec_nxt   = decode(NOP_WORD[27:25], NOP_WORD[22], NOP_WORD[7:4]);
      mov_nxt   = 1'b0;
      irv_nxt   = 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (MFC) begin
            state_nxt = HOLD;
            ir_nxt    = MemData;
            dec_nxt   = decode(MemData[27:25], MemData[22], MemData[7:4]);
            irv_nxt   = 1'b1;
            mov_nxt   = 1'b0;
          end else if (cnt == CNT_LAST) begin
            // Give up: IR and its decode keep the previous instruction.
            state_nxt = IDLE;
            mov_nxt   = 1'b0;
            err_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          // IDLE and HOLD behave alike: wait for a request, ignore MFC.
          if (IR_LD) begin
            state_nxt = FETCH;
            cnt_nxt   = '0;
            mov_nxt   = 1'b1;
            irv_nxt   = 1'b0;
            err_nxt   = 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_register.sv
module tb_instruction_fetch_register;

  localparam int unsigned TIMEOUT = 15;
  localparam logic        SEXT    = 1'b0;
  localparam logic [31:0] NOP     = 32'hE1A00000;

  logic        Clk;
  logic        Clr;
  logic        IR_LD;
  logic        Flush;
  logic        MFC;
  logic [31:0] MemData;
  logic        MOV;
  logic [31:0] IR;
  logic [1:0]  SISE;
  logic        EN;
  logic        ImmValid;
  logic        IRV;
  logic        FetchErr;

  instruction_fetch_register #(
    .TIMEOUT(TIMEOUT), .SEXT_DEFAULT(SEXT), .NOP_WORD(NOP)
  ) dut (
    .Clk(Clk), .Clr(Clr), .IR_LD(IR_LD), .Flush(Flush), .MFC(MFC),
    .MemData(MemData), .MOV(MOV), .IR(IR), .SISE(SISE), .EN(EN),
    .ImmValid(ImmValid), .IRV(IRV), .FetchErr(FetchErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: a pending request plus the number of cycles it has waited.
  bit          m_busy;
  int          m_waited;
  logic        m_mov;
  logic [31:0] m_ir;
  logic [1:0]  m_sise;
  logic        m_immv;
  logic        m_en;
  logic        m_irv;
  logic        m_err;

  // Immediate-format classification by masked compares on the whole word.
  function automatic logic [2:0] m_decode(input logic [31:0] w);
    if ((w & 32'h0E000000) == 32'h02000000) return 3'b001;
    if ((w & 32'h0E000000) == 32'h04000000) return 3'b011;
    if (((w & 32'h0E400090) == 32'h00400090) && ((w & 32'h00000060) != 0)) return 3'b101;
    return 3'b110;
  endfunction

  task automatic m_load(input logic [31:0] w);
    logic [2:0] d;
    d      = m_decode(w);
    m_ir   = w;
    m_sise = d[2:1];
    m_immv = d[0];
    m_en   = d[0] ? SEXT : 1'b0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_waited = 0; m_mov = 0; m_ir = 0; m_sise = 0;
    m_immv = 0; m_en = 0; m_irv = 0; m_err = 0;
  endtask

  task automatic model_step();
    if (Flush) begin
      m_busy = 0; m_mov = 0; m_irv = 0;
      m_load(NOP);
    end else if (m_busy) begin
      if (MFC) begin
        m_busy = 0; m_mov = 0; m_irv = 1;
        m_load(MemData);
      end else begin
        m_waited++;
        if (m_waited == int'(TIMEOUT)) begin
          m_busy = 0; m_mov = 0; m_err = 1;
        end
      end
    end else if (IR_LD) begin
      m_busy = 1; m_waited = 0; m_mov = 1; m_irv = 0; m_err = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("MOV", 32'(MOV), 32'(m_mov));
    chk("IR", IR, m_ir);
    chk("SISE", 32'(SISE), 32'(m_sise));
    chk("ImmValid", 32'(ImmValid), 32'(m_immv));
    chk("EN", 32'(EN), 32'(m_en));
    chk("IRV", 32'(IRV), 32'(m_irv));
    chk("FetchErr", 32'(FetchErr), 32'(m_err));
  endtask

  // One clock: drive at negedge, step model at posedge, compare at next negedge.
  task automatic cycle(input logic ld, input logic fl, input logic mf, input logic [31:0] d);
    IR_LD = ld; Flush = fl; MFC = mf; MemData = d;
    @(posedge Clk);
    if (!Clr) model_reset();
    else model_step();
    @(negedge Clk);
    compare_all();
  endtask

  // Pull Clr low between edges, check immediately, hold over one edge, release.
  task automatic async_reset();
    #2 Clr = 1'b0;
    #1 model_reset();
    compare_all();
    chk("rst_mov_now", 32'(MOV), 32'd0);
    chk("rst_ir_now", IR, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
    Clr = 1'b1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: w = (w & ~32'h0E000000) | 32'h02000000;
      1: w = (w & ~32'h0E000000) | 32'h04000000;
      2: w = (w & ~32'h0E000000) | 32'h00400090;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    int movcnt;
    IR_LD = 0; Flush = 0; MFC = 0; MemData = 0;
    Clr = 1'b1;
    #1 Clr = 1'b0;
    model_reset();
    @(negedge Clk);
    compare_all();
    chk("reset_ir", IR, 32'd0);
    chk("reset_sise", 32'(SISE), 32'd0);
    Clr = 1'b1;

    // Minimum-latency fetch.
    cycle(1, 0, 0, 0);
    chk("t1_mov", 32'(MOV), 32'd1);
    cycle(0, 0, 1, 32'hE3A010FF);
    chk("t1_ir", IR, 32'hE3A010FF);
    chk("t1_sise", 32'(SISE), 32'd0);
    chk("t1_immv", 32'(ImmValid), 32'd1);
    chk("t1_irv", 32'(IRV), 32'd1);
    chk("t1_mov_low", 32'(MOV), 32'd0);

    // MFC after five MOV cycles.
    movcnt = 0;
    cycle(1, 0, 0, 0);
    movcnt += int'(MOV);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, $urandom);
      movcnt += int'(MOV);
    end
    cycle(0, 0, 1, 32'hE5912ABC);
    movcnt += int'(MOV);
    chk("t2_movcnt", 32'(movcnt), 32'd5);
    chk("t2_sise", 32'(SISE), 32'd1);

    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 32'hE1D120B4);
    chk("t3_sise", 32'(SISE), 32'd2);
    chk("t3_immv", 32'(ImmValid), 32'd1);

    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 32'hEA000010);
    chk("t4_sise", 32'(SISE), 32'd3);
    chk("t4_immv", 32'(ImmValid), 32'd0);

    // Timeout.
    movcnt = 0;
    cycle(1, 0, 0, 0);
    movcnt += int'(MOV);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0, $urandom);
      movcnt += int'(MOV);
    end
    chk("to_movcnt", 32'(movcnt), 32'(TIMEOUT));
    chk("to_err", 32'(FetchErr), 32'd1);
    chk("to_ir", IR, 32'hEA000010);
    cycle(1, 0, 0, 0);
    chk("to_err_clr", 32'(FetchErr), 32'd0);
    // MFC on the final waiting cycle still completes.
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'hE5912ABC);
    chk("to_last_irv", 32'(IRV), 32'd1);
    chk("to_last_err", 32'(FetchErr), 32'd0);

    // Flush beats MFC.
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 32'hE3A010FF);
    chk("fl_ir", IR, NOP);
    chk("fl_irv", 32'(IRV), 32'd0);
    chk("fl_mov", 32'(MOV), 32'd0);
    chk("fl_immv", 32'(ImmValid), 32'd0);

    // Asynchronous reset mid-fetch, then MFC ignored in IDLE.
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 32'hE5912ABC);
    cycle(1, 0, 0, 0);
    async_reset();
    cycle(0, 0, 1, 32'hE3A010FF);
    chk("rst_idle_irv", 32'(IRV), 32'd0);
    chk("rst_idle_ir", IR, 32'd0);

    // Back-to-back fetches with IR_LD held high.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 32'hE5912ABC);
    chk("b2b_irv1", 32'(IRV), 32'd1);
    cycle(1, 0, 0, 0);
    chk("b2b_irv_drop", 32'(IRV), 32'd0);
    chk("b2b_ir_keep", IR, 32'hE5912ABC);
    cycle(1, 0, 1, 32'hE1D120B4);
    chk("b2b_sise", 32'(SISE), 32'd2);

    // IR_LD pulses during FETCH are ignored.
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 32'hEA000010);
    cycle(0, 0, 0, 0);
    chk("pulse_mov", 32'(MOV), 32'd0);
    chk("pulse_irv", 32'(IRV), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) async_reset();
      else cycle($urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 4) == 0, rand_word());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
